// File: rtl/serial_add_sequencer_if.sv
// Handshake and operand/result bundle for serial_add_sequencer.
// SERIAL_ADD_SEQUENCER_SUB_EN adds the sub request bit.
interface serial_add_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SEQUENCER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cOut;

  modport master (
`ifdef SERIAL_ADD_SEQUENCER_SUB_EN
    output sub,
`endif
    output start, a, b,
    input  busy, done, sum, cOut
  );

  modport slave (
`ifdef SERIAL_ADD_SEQUENCER_SUB_EN
    input  sub,
`endif
    input  start, a, b,
    output busy, done, sum, cOut
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder: one full-adder slice walked LSB-first over WIDTH cycles.
// Optional subtract mode under SERIAL_ADD_SEQUENCER_SUB_EN.
module serial_add_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input logic                   clk,
  input logic                   reset_n,
  serial_add_sequencer_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic sub_in;
`ifdef SERIAL_ADD_SEQUENCER_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  // Full-adder slice as two half adders joined by an OR on the carries.
  logic ha0_s, ha0_c, ha1_s, ha1_c, slice_c;
  always_comb begin
    ha0_s   = a_q[0] ^ b_q[0];
    ha0_c   = a_q[0] & b_q[0];
    ha1_s   = ha0_s ^ carry_q;
    ha1_c   = ha0_s & carry_q;
    slice_c = ha0_c | ha1_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // The DONE->IDLE edge also samples start so back-to-back ops take WIDTH+1 cycles.
        StIdle, StDone: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= sub_in ? ~bus.b : bus.b;
            carry_q <= sub_in;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRun: begin
          sum_q   <= {ha1_s, sum_q[WIDTH-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= slice_c;
          if (cnt_q == CntLast) begin
            cout_q  <= slice_c;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cOut = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench for serial_add_sequencer: WIDTH=8 directed cases and WIDTH=4 exhaustive sweep.
module tb_serial_add_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_sequencer_if #(.WIDTH(8)) b8 ();
  serial_add_sequencer_if #(.WIDTH(4)) b4 ();

  serial_add_sequencer #(.WIDTH(8)) u_dut8 (.clk(clk), .reset_n(rst_n), .bus(b8));
  serial_add_sequencer #(.WIDTH(4)) u_dut4 (.clk(clk), .reset_n(rst_n), .bus(b4));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] f8(input logic [7:0] a, input logic [7:0] b, input logic s);
    return {1'b0, a} + {1'b0, (s ? ~b : b)} + 9'(s);
  endfunction

  logic s8;
`ifdef SERIAL_ADD_SEQUENCER_SUB_EN
  assign s8 = b8.sub;
`else
  assign s8 = 1'b0;
`endif

  // Model: cnt = cycles left until IDLE; cnt==1 is the DONE cycle, where a new start is taken.
  int         cnt8 = 0;
  int         cnt4 = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [8:0] last8 = '0;
  logic [4:0] last4 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt8 <= 0;
      cnt4 <= 0;
    end else begin
      if (cnt8 <= 1 && b8.start) begin
        cnt8 <= 9;
        q8.push_back(f8(b8.a, b8.b, s8));
      end else if (cnt8 > 0) begin
        cnt8 <= cnt8 - 1;
      end
      if (cnt4 <= 1 && b4.start) begin
        cnt4 <= 5;
        q4.push_back({1'b0, b4.a} + {1'b0, b4.b});
      end else if (cnt4 > 0) begin
        cnt4 <= cnt4 - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
      q4.delete();
      last8 = '0;
      last4 = '0;
    end else begin
      check("busy8", b8.busy, cnt8 != 0);
      check("done8", b8.done, cnt8 == 1);
      if (cnt8 == 1) begin
        check("sb8_has_entry", q8.size() > 0, 1);
        if (q8.size() > 0) last8 = q8.pop_front();
        check("res8", {b8.cOut, b8.sum}, last8);
      end else if (cnt8 == 0) begin
        check("hold8", {b8.cOut, b8.sum}, last8);
      end
      check("busy4", b4.busy, cnt4 != 0);
      check("done4", b4.done, cnt4 == 1);
      if (cnt4 == 1) begin
        check("sb4_has_entry", q4.size() > 0, 1);
        if (q4.size() > 0) last4 = q4.pop_front();
        check("res4", {b4.cOut, b4.sum}, last4);
      end else if (cnt4 == 0) begin
        check("hold4", {b4.cOut, b4.sum}, last4);
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    b8.a = a;
    b8.b = b;
`ifdef SERIAL_ADD_SEQUENCER_SUB_EN
    b8.sub = s;
`else
    if (s) $display("sub request dropped: feature not built");
`endif
    b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    b4.a = a;
    b4.b = b;
    b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    b8.start = 1'b0; b8.a = '0; b8.b = '0;
    b4.start = 1'b0; b4.a = '0; b4.b = '0;
`ifdef SERIAL_ADD_SEQUENCER_SUB_EN
    b8.sub = 1'b0;
    b4.sub = 1'b0;
`endif
    #12;
    check("rst_busy", b8.busy, 0);
    check("rst_done", b8.done, 0);
    check("rst_res", {b8.cOut, b8.sum}, 9'h000);
    rst_n = 1'b1;

    op8(8'h35, 8'h4A, 1'b0);
    check("t1_result", {b8.cOut, b8.sum}, 9'h07F);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hFF, 8'hFF, 1'b0);
    check("t2_result", {b8.cOut, b8.sum}, 9'h1FE);

    // Held start; a changes while the second op is in flight.
    @(negedge clk);
    b8.a = 8'h10; b8.b = 8'h20; b8.start = 1'b1;
    repeat (12) @(negedge clk);
    b8.a = 8'h01;
    repeat (18) @(negedge clk);
    b8.start = 1'b0;
    repeat (12) @(negedge clk);
    check("t3_last", {b8.cOut, b8.sum}, 9'h021);

    // Reset three cycles into a run.
    @(negedge clk);
    b8.a = 8'hAA; b8.b = 8'h77; b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_busy", b8.busy, 0);
    check("t4_done", b8.done, 0);
    check("t4_res", {b8.cOut, b8.sum}, 9'h000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    op8(8'h02, 8'h03, 1'b0);
    check("t4_after", {b8.cOut, b8.sum}, 9'h005);

    for (int i = 0; i < 256; i++) op4(4'(i >> 4), 4'(i));
    check("t5_last", {b4.cOut, b4.sum}, 5'h1E);

`ifdef SERIAL_ADD_SEQUENCER_SUB_EN
    op8(8'h10, 8'h20, 1'b1);
    check("t6_sub_borrow", {b8.cOut, b8.sum}, 9'h0F0);
    op8(8'h20, 8'h10, 1'b1);
    check("t6_sub_ok", {b8.cOut, b8.sum}, 9'h110);
    op8(8'h20, 8'h10, 1'b0);
    check("t6_add", {b8.cOut, b8.sum}, 9'h030);
`endif

    repeat (3) @(negedge clk);
    check("sb8_drained", q8.size(), 0);
    check("sb4_drained", q4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
